// File: rtl/reg_bank_sequencer_if.sv
// Requester-side and register-bank-side signal bundle for reg_bank_sequencer.
// The sequencer takes the slave view; clients plus the register bank take the master view.
interface reg_bank_sequencer_if #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 6,
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]  req_wdata;
  logic [NUM_REQ-1:0]        ack;
  logic                      err;
  logic [WIDTH-1:0]          rdata;
  logic [NUM_REGS-1:0]       reg_write;
  logic [NUM_REGS-1:0]       reg_enable;
  logic [WIDTH-1:0]          bus_wdata;
  logic [WIDTH-1:0]          bus_rdata;
  logic                      busy;

  modport slave (
    input  req, req_we, req_addr, req_wdata, bus_rdata,
    output ack, err, rdata, reg_write, reg_enable, bus_wdata, busy
  );

  modport master (
    output req, req_we, req_addr, req_wdata, bus_rdata,
    input  ack, err, rdata, reg_write, reg_enable, bus_wdata, busy
  );
endinterface

// File: rtl/reg_bank_sequencer.sv
// Round-robin sequencer sharing a bank of registers between several requesters.
// Every output is decoded from flops, so no input reaches an output combinationally.
module reg_bank_sequencer #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 6,
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  reg_bank_sequencer_if.slave bank_if
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_WR     = 3'd2,
    S_RD_EN  = 3'd3,
    S_RD_CAP = 3'd4,
    S_RD_ACK = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]   bus_wdata_q;
  logic [WIDTH-1:0]   rdata_q;

  logic               grant_vld_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic               win_we_s;
  logic [ADDR_W-1:0]  win_addr_s;
  logic [WIDTH-1:0]   win_wdata_s;
  logic               win_oor_s;
  logic [NUM_REGS-1:0] sel_s;
  logic [NUM_REGS-1:0] write_s;
  logic [NUM_REGS-1:0] enable_s;
  logic [NUM_REQ-1:0]  ack_s;
  logic                err_s;

  // Round-robin search from ptr upward with wrap; first requester found wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld_s && bank_if.req[(int'(ptr_q) + k) % NUM_REQ]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
    win_we_s    = bank_if.req_we[grant_idx_s];
    win_addr_s  = bank_if.req_addr[int'(grant_idx_s) * ADDR_W +: ADDR_W];
    win_wdata_s = bank_if.req_wdata[int'(grant_idx_s) * WIDTH +: WIDTH];
    win_oor_s   = (int'(win_addr_s) >= NUM_REGS);
  end

  // Next-state logic: one grant per IDLE visit, fixed-length walk back to IDLE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    case (state_q)
      S_INIT:   state_d = S_IDLE;
      S_IDLE: begin
        if (grant_vld_s) begin
          idx_d  = grant_idx_s;
          addr_d = win_addr_s;
          ptr_d  = IDX_W'((int'(grant_idx_s) + 1) % NUM_REQ);
          if (win_oor_s) begin
            state_d = S_ERR;
          end else if (win_we_s) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD_EN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR:     state_d = S_IDLE;
      S_RD_EN:  state_d = S_RD_CAP;
      S_RD_CAP: state_d = S_RD_ACK;
      S_RD_ACK: state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase
  end

  // State, arbitration pointer, latched request and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      ptr_q       <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      // Write data goes straight onto the shared bus so it holds between writes.
      if (state_q == S_IDLE && state_d == S_WR) begin
        bus_wdata_q <= win_wdata_s;
      end
      if (state_q == S_RD_CAP) begin
        rdata_q <= bank_if.bus_rdata;
      end
    end
  end

  // Strobe and completion decode from the current state and latched fields.
  always_comb begin
    sel_s    = {{(NUM_REGS-1){1'b0}}, 1'b1} << addr_q;
    write_s  = '0;
    enable_s = '0;
    ack_s    = '0;
    err_s    = 1'b0;
    case (state_q)
      S_WR: begin
        write_s = sel_s;
        ack_s   = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;
      end
      S_RD_EN:  enable_s = sel_s;
      S_RD_ACK: ack_s    = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;
      S_ERR: begin
        ack_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;
        err_s = 1'b1;
      end
      default: begin
        write_s = '0;
      end
    endcase
  end

  assign bank_if.reg_write  = write_s;
  assign bank_if.reg_enable = enable_s;
  assign bank_if.ack        = ack_s;
  assign bank_if.err        = err_s;
  assign bank_if.bus_wdata  = bus_wdata_q;
  assign bank_if.rdata      = rdata_q;
  assign bank_if.busy       = (state_q != S_IDLE);
endmodule

// File: doc/reg_bank_sequencer.md
# reg_bank_sequencer

Controller that shares a bank of `register` instances between several requesters. It arbitrates round-robin and drives one-hot `write`/`enable` strobes plus a shared write-data bus. It captures read data from the shared tri-state read bus formed by the registers' `data_out`. It sits between datapath clients (control unit, debug port, etc.) and the register bank, and guarantees that at most one register drives the bus in any cycle.

## Interface
- `WIDTH`, 32: data width, matches the registers' `WIDTH`.
- `NUM_REGS`, 6: number of registers in the bank.
- `NUM_REQ`, 4: number of requesters.
- `ADDR_W`, `$clog2(NUM_REGS)` (derived, min 1): register address width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  NUM_REQ  per-requester request, level.
- `req_we`  in  NUM_REQ  per-requester 1=write, 0=read.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i is slice [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_REQ*WIDTH  packed write data; slice [i*WIDTH +: WIDTH].
- `ack`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `err`  out  1  high with `ack` when the address was out of range.
- `rdata`  out  WIDTH  read result, valid while `ack` is high on a read.
- `reg_write`  out  NUM_REGS  one-hot to the registers' `write` inputs.
- `reg_enable`  out  NUM_REGS  one-hot to the registers' `enable` inputs.
- `bus_wdata`  out  WIDTH  shared `data_in` for all registers.
- `bus_rdata`  in  WIDTH  wired bus of all registers' `data_out`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- All outputs are decoded from flops only, with no combinational path from inputs to outputs.
- FSM states: INIT, IDLE, WR, RD_EN, RD_CAP, RD_ACK, ERR.
- **INIT:**
  - Entered on reset. Lasts exactly one cycle after `rst` deasserts.
  - All enables are low, so every register's `data_out` goes Z. The registers hold `data_out` while in reset.
  - Next state: IDLE.
- **IDLE:**
  - If any `req` is high, pick the winner round-robin.
  - Search starts at `ptr`, ascending with wrap.
  - Latch the winner's index, we, addr and wdata.
  - Set `ptr` to winner+1 (mod NUM_REQ).
  - Next state: ERR if addr ≥ NUM_REGS, else WR if we=1, else RD_EN.
  - If no `req` is high, stay in IDLE and leave `ptr` unchanged.
- **WR:**
  - `reg_write[addr]`=1 and `bus_wdata`=latched wdata.
  - `ack[idx]`=1 and `err`=0.
  - Next state: IDLE.
- **RD_EN:**
  - `reg_enable[addr]`=1. The register loads `data_out` at the end of this cycle.
  - Next state: RD_CAP.
- **RD_CAP:**
  - All enables are 0.
  - `bus_rdata` is sampled into `rdata` at the end of this cycle, while the register still drives the bus.
  - Next state: RD_ACK.
- **RD_ACK:**
  - `ack[idx]`=1, `err`=0, `rdata` valid.
  - Next state: IDLE.
- **ERR:**
  - No strobes asserted.
  - `ack[idx]`=1, `err`=1. `rdata` is unchanged.
  - Next state: IDLE.
- **Requester rules:**
  - A requester holds `req`, `req_we`, `req_addr` and `req_wdata` stable until it sees `ack`.
  - It deasserts `req` in the cycle after `ack`, or keeps it high to queue a new request.
  - Fields are latched in IDLE, so changes after the grant are ignored.
  - A request withdrawn after being latched still completes and is acked.
- **Invariants:**
  - `popcount(reg_write) + popcount(reg_enable)` ≤ 1 in every cycle.
  - `ack` is one-hot or zero.
  - `bus_wdata` holds its last value outside WR.

## Timing
- Reset values:
  - State = INIT, `ptr`=0.
  - `ack`=0, `err`=0, `rdata`=0.
  - `reg_write`=0, `reg_enable`=0, `bus_wdata`=0.
  - `busy`=1 (in INIT).
- Write latency: grant decided in IDLE (cycle 0), WR with `ack` in cycle 1. Minimum period between writes is 2 cycles.
- Read latency: IDLE (cycle 0), RD_EN (1), RD_CAP (2), RD_ACK with `ack`+`rdata` (3). Minimum period between reads is 4 cycles.
- Error latency: IDLE (0), ERR with `ack` (1).
- Bus turnaround: the enabled register goes Z at the end of RD_CAP. The next RD_EN is at least 2 cycles later, so the bus never has two drivers.
- Reset mid-operation: at the next edge the state is INIT and all strobes and `ack` are 0. The pending transaction is dropped without an ack, and `ptr` is reset to 0.
- Simultaneous requests: exactly one grant per IDLE visit. Losers wait in IDLE and are granted within NUM_REQ transactions.
- `rst` high in INIT: stay in INIT.

## Test plan
- Reset then write: req0 writes addr 2 with 0xDEADBEEF.
  - INIT lasts 1 cycle.
  - `reg_write`=6'b000100 for one cycle, `bus_wdata`=0xDEADBEEF.
  - `ack`=4'b0001 in the same cycle, `err`=0.
- Readback: req1 reads addr 2 after the write above.
  - `reg_enable`=6'b000100 exactly one cycle.
  - 3 cycles after IDLE, `ack`=4'b0010 with `rdata`=0xDEADBEEF.
- Contention: req0..req3 all assert reads at once from reset.
  - Grants occur in order 0,1,2,3.
  - Continuously held req0 and req2 then alternate 0,2,0,2.
- Out of range: req3 writes addr 7 (NUM_REGS=6).
  - No strobes asserted.
  - `ack`=4'b1000 with `err`=1 one cycle after IDLE.
- Reset mid-read: assert `rst` during RD_CAP.
  - Next cycle: INIT, `reg_enable`=0, no `ack`.
  - After INIT, an old request still held is re-arbitrated starting from ptr=0.
- Exclusivity checker: random requests for 10k cycles.
  - Assert ≤1 strobe per cycle.
  - Assert ack one-hot or zero.
  - Assert every read returns the last value written to that address.
